// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle ops and
// iterative shift-add multiply / restoring divide.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             sign,
   output logic             carry,
   output logic             overflow,
   output logic             div_zero,
   output logic             illegal_op,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic                 div_q, div_d;
   logic                 hi_q, hi_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic [5:0]           flg_q, flg_d;

   logic [SHW-1:0]       shamt;
   logic [WIDTH:0]       add_w, sub_w;
   logic [WIDTH-1:0]     sc_res;
   logic                 sc_c, sc_o, sc_dz, sc_ill, sc_iter;
   logic [WIDTH:0]       mul_s, div_s;
   logic [2*WIDTH-1:0]   step;
   logic [WIDTH-1:0]     fin;

   assign shamt     = src_b[SHW-1:0];
   assign in_ready  = (state_q == IDLE) ||
                      ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == BUSY);
   assign result    = res_q;
   assign {zero, sign, carry, overflow, div_zero, illegal_op} = flg_q;

   // Single-cycle datapath and iterative-op detection from live inputs.
   always_comb begin
      add_w   = {1'b0, src_a} + {1'b0, src_b};
      sub_w   = {1'b0, src_a} - {1'b0, src_b};
      sc_res  = '0;
      sc_c    = 1'b0;
      sc_o    = 1'b0;
      sc_dz   = 1'b0;
      sc_ill  = 1'b0;
      sc_iter = 1'b0;
      unique case (op)
         4'b0000: begin
            sc_res = add_w[WIDTH-1:0];
            sc_c   = add_w[WIDTH];
            sc_o   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                     (add_w[WIDTH-1] != src_a[WIDTH-1]);
         end
         4'b0001: sc_res = src_a << shamt;
         4'b0010: begin
            sc_res = sub_w[WIDTH-1:0];
            sc_c   = ~sub_w[WIDTH];
            sc_o   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                     (sub_w[WIDTH-1] != src_a[WIDTH-1]);
         end
         4'b0011: sc_res = {{(WIDTH-1){1'b0}},
                            $signed(src_a) < $signed(src_b)};
         4'b0100: sc_res = src_a ^ src_b;
         4'b0101: sc_res = src_a >> shamt;
         4'b0110: sc_res = src_a | src_b;
         4'b0111: sc_res = src_a & src_b;
         4'b1000: sc_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
         4'b1001: sc_res = WIDTH'($signed(src_a) >>> shamt);
         4'b1010, 4'b1011: sc_iter = 1'b1;
         4'b1100: begin
            if (src_b == '0) begin
               sc_res = '1;
               sc_dz  = 1'b1;
            end else begin
               sc_iter = 1'b1;
            end
         end
         4'b1101: begin
            if (src_b == '0) begin
               sc_res = src_a;
               sc_dz  = 1'b1;
            end else begin
               sc_iter = 1'b1;
            end
         end
         default: sc_ill = 1'b1;
      endcase
   end

   // One multiply or divide iteration on the {hi,lo} accumulator.
   always_comb begin
      mul_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, b_q} : '0);
      div_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
      if (div_q) begin
         step = div_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
              : {div_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         step = {mul_s, acc_q[WIDTH-1:1]};
      end
      fin = hi_q ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
   end

   // Next-state: flush first, then accept/iterate/retire.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      div_d   = div_q;
      hi_d    = hi_q;
      res_d   = res_q;
      flg_d   = flg_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            BUSY: begin
               acc_d = step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  res_d   = fin;
                  flg_d   = {fin == '0, fin[WIDTH-1], 4'b0000};
               end
            end
            default: begin
               if (state_q == DONE && out_ready) state_d = IDLE;
               if (in_valid && in_ready) begin
                  if (sc_iter) begin
                     state_d = BUSY;
                     cnt_d   = '0;
                     acc_d   = {{WIDTH{1'b0}}, src_a};
                     b_d     = src_b;
                     div_d   = op[2];
                     hi_d    = op[0];
                  end else begin
                     state_d = DONE;
                     res_d   = sc_res;
                     flg_d   = {sc_res == '0, sc_res[WIDTH-1],
                                sc_c, sc_o, sc_dz, sc_ill};
                  end
               end
            end
         endcase
      end
   end

   // State, operand, accumulator and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         div_q   <= 1'b0;
         hi_q    <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         div_q   <= div_d;
         hi_q    <= hi_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results
// for seq_alu at WIDTH=32.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [31:0] src_a, src_b, result;
   logic        zero, sign, carry, overflow, div_zero, illegal_op, busy;
   int          n_chk = 0;
   int          n_fail = 0;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero),
      .sign(sign), .carry(carry), .overflow(overflow),
      .div_zero(div_zero), .illegal_op(illegal_op), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] flags();
      return {zero, sign, carry, overflow, div_zero, illegal_op};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue at a negedge, wait for out_valid, check latency/result/flags.
   task automatic run_op(input string tag, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [5:0] ef,
                         input int el);
      int lat = 0;
      in_valid  = 1'b1;
      op        = o;
      src_a     = a;
      src_b     = b;
      out_ready = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         in_valid = 1'b0;
         src_a    = ~a;
         src_b    = ~b;
      end while (!out_valid && lat < 100);
      chk({tag, "_lat"}, 64'(lat), 64'(el));
      chk({tag, "_res"}, 64'(result), 64'(er));
      chk({tag, "_flg"}, 64'(flags()), 64'(ef));
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 4'h0; src_a = '0; src_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_res", 64'(result), 64'd0);
      chk("rst_flg", 64'(flags()), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // flags order: zero sign carry overflow div_zero illegal_op
      run_op("add", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 6'b101000, 1);
      run_op("sub", 4'h2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF,
             6'b001100, 1);
      run_op("subb", 4'h2, 32'h1, 32'h2, 32'hFFFF_FFFF, 6'b010000, 1);
      run_op("sra", 4'h9, 32'h8000_0000, 32'h104, 32'hF800_0000,
             6'b010000, 1);
      run_op("srl", 4'h5, 32'h8000_0000, 32'h104, 32'h0800_0000,
             6'b000000, 1);
      run_op("sll", 4'h1, 32'h1, 32'h3F, 32'h8000_0000, 6'b010000, 1);
      run_op("slt", 4'h3, 32'hFFFF_FFFF, 32'h1, 32'h1, 6'b000000, 1);
      run_op("sltu", 4'h8, 32'hFFFF_FFFF, 32'h1, 32'h0, 6'b100000, 1);
      run_op("and", 4'h7, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200,
             6'b000000, 1);
      run_op("ill", 4'hE, 32'h5, 32'h6, 32'h0, 6'b100001, 1);
      run_op("mul", 4'hA, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001,
             6'b000000, 33);
      run_op("mulhu", 4'hB, 32'h0001_0001, 32'h0001_0001, 32'h1,
             6'b000000, 33);
      run_op("mulhu2", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 6'b010000, 33);
      run_op("divu", 4'hC, 32'd100, 32'd7, 32'd14, 6'b000000, 33);
      run_op("remu", 4'hD, 32'd100, 32'd7, 32'd2, 6'b000000, 33);
      run_op("divu_big", 4'hC, 32'hFFFF_FFFF, 32'h3, 32'h5555_5555,
             6'b000000, 33);
      run_op("divz", 4'hC, 32'd100, 32'd0, 32'hFFFF_FFFF, 6'b010010, 1);
      run_op("remz", 4'hD, 32'd5, 32'd0, 32'd5, 6'b000010, 1);

      // back-to-back single-cycle ops
      in_valid = 1'b1; out_ready = 1'b1;
      op = 4'h0; src_a = 32'd3; src_b = 32'd4;
      @(negedge clk);
      chk("b2b_add", 64'(result), 64'd7);
      chk("b2b_rdy0", 64'(in_ready), 64'd1);
      op = 4'h4; src_a = 32'hF0; src_b = 32'hFF;
      @(negedge clk);
      chk("b2b_xor", 64'(result), 64'h0F);
      chk("b2b_rdy1", 64'(in_ready), 64'd1);
      op = 4'h6; src_a = 32'hF0; src_b = 32'h0F;
      @(negedge clk);
      chk("b2b_or", 64'(result), 64'hFF);
      chk("b2b_vld", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      op = 4'h0; src_a = 32'd1; src_b = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_res", 64'(result), 64'hFF);
         chk("hold_rdy", 64'(in_ready), 64'd0);
         chk("hold_vld", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("retire_acc", 64'(result), 64'd2);
      in_valid = 1'b0;
      @(negedge clk);
      chk("idle_vld", 64'(out_valid), 64'd0);

      // flush mid-divide, with a competing request
      in_valid = 1'b1; op = 4'hC; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("fl_busy", 64'(busy), 64'd1);
      flush = 1'b1; in_valid = 1'b1; op = 4'h0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_busy0", 64'(busy), 64'd0);
      chk("fl_vld", 64'(out_valid), 64'd0);
      chk("fl_rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("fl_noacc", 64'(out_valid), 64'd0);

      // async reset mid-multiply
      in_valid = 1'b1; op = 4'hA; src_a = 32'd9; src_b = 32'd9;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_rdy", 64'(in_ready), 64'd1);
      chk("ar_vld", 64'(out_valid), 64'd0);
      chk("ar_res", 64'(result), 64'd0);
      chk("ar_flg", 64'(flags()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("post_rst", 4'hA, 32'd9, 32'd9, 32'd81, 6'b000000, 33);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU of the core.
- Width is set by WIDTH. Adds SLT/SLTU/SRA, carry/overflow flags, and iterative multi-cycle MUL/MULHU/DIVU/REMU.
- Sits between the execute-stage operand muxes and writeback. The pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from src_b.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current operation.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept an operation.
- op  in  4  operation code.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- sign  out  1  result[WIDTH-1].
- carry  out  1  ADD carry-out / SUB no-borrow; 0 for other ops.
- overflow  out  1  signed overflow for ADD/SUB; 0 for other ops.
- div_zero  out  1  DIVU/REMU with src_b == 0.
- illegal_op  out  1  op 1110/1111.
- busy  out  1  iterative operation in progress.

Behaviour:
- Reset (rst_n low, async): state IDLE, in_ready 1, out_valid 0, result 0, all flags 0, busy 0, iteration counter 0.
- States:
  - IDLE: accept an operation on in_valid && in_ready.
  - BUSY: iterating.
  - DONE: out_valid = 1, result and flags frozen until out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back single-cycle ops at one op per cycle.
- Op codes:
  - 0000 ADD; 0001 SLL; 0010 SUB; 0011 SLT (signed, result 0/1); 0100 XOR; 0101 SRL; 0110 OR; 0111 AND.
  - 1000 SLTU; 1001 SRA; 1010 MUL (low WIDTH bits); 1011 MULHU (high WIDTH bits, unsigned); 1100 DIVU; 1101 REMU.
  - 1110/1111 illegal: result 0, illegal_op 1.
- Shift amount is src_b[SHW-1:0]; upper src_b bits are ignored. SRA replicates src_a[WIDTH-1].
- Single-cycle ops (all except 1010–1101, and DIVU/REMU with src_b==0): result is registered at the accept edge and out_valid is high the next cycle. Latency 1.
- MUL/MULHU: unsigned shift-add over a 2*WIDTH accumulator. BUSY for exactly WIDTH cycles, then DONE. out_valid rises WIDTH+1 cycles after accept.
- DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH cycles in BUSY, same latency as MUL.
- Divide by zero: DIVU result all ones, REMU result = src_a, div_zero 1, latency 1; no iteration.
- Flags:
  - Registered with result and held while out_valid.
  - zero/sign are derived from the final result for every op.
  - carry/overflow are defined only for ADD/SUB, else 0.
  - SUB carry = 1 when src_a >= src_b unsigned.
  - div_zero/illegal_op are 0 unless their condition holds.
- Operands are captured at accept; input changes during BUSY are ignored.
- busy = (state==BUSY). in_ready is 0 in BUSY.
- flush (synchronous):
  - Takes priority over everything: next state IDLE, out_valid 0, counter cleared.
  - result/flags keep stale values but are not valid.
  - Any in_valid in the same cycle is not accepted.
- DONE with out_ready=0: hold result/flags indefinitely; no new accept.
- DONE with out_ready=1 and in_valid=1: result retired and new op accepted in the same edge; next state per the new op.
- Async reset mid-BUSY: immediate return to reset values; the partial result is discarded.

Test Plan:
1. Reset then ADD (WIDTH=32): src_a=0xFFFFFFFF, src_b=1 -> after 1 cycle result=0, zero=1, carry=1, overflow=0.
2. SUB src_a=0x80000000, src_b=1 -> result=0x7FFFFFFF, overflow=1, carry=1. SRA src_a=0x80000000, src_b=0x00000104 -> result=0xF8000000 (shift 4; upper src_b bits ignored).
3. MUL src_a=0x00010001, src_b=0x00010001 with out_ready=1 -> busy for 32 cycles, out_valid on cycle 33, result=0x00020001. MULHU same operands -> result=0x00000001.
4. DIVU src_a=100, src_b=7 -> 33-cycle latency, result=14. REMU -> result=2. DIVU src_b=0 -> 1-cycle latency, result=0xFFFFFFFF, div_zero=1.
5. Back-to-back ADD, XOR, OR with in_valid and out_ready held high -> one result per cycle, in_ready constantly 1. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
6. Assert flush at cycle 10 of a DIVU -> next cycle state IDLE, out_valid=0, in_ready=1. Drop rst_n mid-MUL -> all outputs return to reset values asynchronously.
